jsilicon_core_v2: RTL and testbench

- Parametrised successor of the Jsilicon calculator/CPU top.
- Provides the same two modes as before:
  - Manual mode: one-shot ALU operation on external operands.
  - CPU mode: accumulator machine running a writable program store.
- Generalised data width, program depth and baud divisor.
- New over the previous generation: loadable program, JNZ branch, HALT, status flags, multi-byte UART result framing, explicit start/done handshakes.

---
 rtl/jsilicon_core_v2.sv | 226 ++++++++++++++++++++++
 tb/tb_jsilicon_core_v2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jsilicon_core_v2.sv
// jsilicon_core_v2: manual ALU / accumulator CPU with a loadable program
// store and multi-byte 8N1 UART result framing.
module jsilicon_core_v2 #(
    parameter int DATA_W     = 8,
    parameter int IMM_W      = 4,
    parameter int PROG_DEPTH = 8,
    parameter int CLK_DIV    = 1250
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          mode,
    input  logic [DATA_W-1:0]             man_a,
    input  logic [DATA_W-1:0]             man_b,
    input  logic [2:0]                    man_op,
    input  logic                          man_go,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [3+IMM_W-1:0]            prog_wdata,
    output logic [2*DATA_W-1:0]           result,
    output logic [DATA_W-1:0]             acc,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic                          flag_z,
    output logic                          flag_v,
    output logic                          halted,
    output logic                          done,
    output logic                          uart_tx,
    output logic                          uart_busy
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int RW = 2 * DATA_W;
    localparam int IW = 3 + IMM_W;
    localparam int NB = RW / 8;
    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_TX} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_mem [PROG_DEPTH];
    logic [IW-1:0]       r_ir;
    logic                r_mode;
    logic [DATA_W-1:0]   r_man_a, r_man_b;
    logic [2:0]          r_man_op;
    logic [RW-1:0]       r_result;
    logic [DATA_W-1:0]   r_acc;
    logic [AW-1:0]       r_pc;
    logic                r_z, r_v, r_halted, r_done;
    logic                r_tx, r_busy;
    logic [RW-1:0]       r_tx_sr;
    logic [CW-1:0]       r_byte_cnt;
    logic [3:0]          r_bit;
    logic [BW-1:0]       r_baud;

    logic [2:0]          w_op;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_a, w_b, w_diff;
    logic [RW-1:0]       w_res;
    logic                w_v;
    logic [9:0]          w_frame;
    logic                w_halt_op;

    // Operand/opcode select: manual uses latched inputs, CPU uses acc and imm
    always_comb begin
        w_imm     = r_ir[IMM_W-1:0];
        w_op      = r_mode ? r_ir[IW-1:IMM_W] : r_man_op;
        w_a       = r_mode ? r_acc : r_man_a;
        w_b       = r_mode ? DATA_W'(w_imm) : r_man_b;
        w_halt_op = (w_imm == '1);
        w_frame   = {1'b1, r_tx_sr[7:0], 1'b0};
    end

    // ALU: double-width result, v flag per opcode, op 111 yields zero
    always_comb begin
        w_res  = '0;
        w_v    = 1'b0;
        w_diff = w_a - w_b;
        case (w_op)
            3'd0: begin
                w_res = RW'(w_a) + RW'(w_b);
                w_v   = w_res[DATA_W];
            end
            3'd1: begin
                w_res = RW'(w_diff);
                w_v   = (w_a < w_b);
            end
            3'd2: begin
                w_res = RW'(w_a) * RW'(w_b);
                w_v   = |w_res[RW-1:DATA_W];
            end
            3'd3: begin
                if (w_b == '0) begin
                    w_res = RW'({DATA_W{1'b1}});
                    w_v   = 1'b1;
                end else begin
                    w_res = RW'(w_a / w_b);
                end
            end
            3'd4:    w_res = RW'(w_b);
            3'd5:    w_res = RW'(w_a == w_b);
            3'd6:    w_res = RW'(w_a > w_b);
            default: w_res = '0;
        endcase
    end

    // Program store: written only while idle and enabled; never reset
    always_ff @(posedge clk) begin
        if (!rst && ena && r_state == S_IDLE && prog_we)
            r_mem[prog_addr] <= prog_wdata;
    end

    // Main control FSM, architectural registers and UART serialiser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_mode     <= 1'b0;
            r_man_a    <= '0;
            r_man_b    <= '0;
            r_man_op   <= '0;
            r_result   <= '0;
            r_acc      <= '0;
            r_pc       <= '0;
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_halted   <= 1'b0;
            r_done     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_sr    <= '0;
            r_byte_cnt <= '0;
            r_bit      <= '0;
            r_baud     <= '0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (prog_we || !run) r_halted <= 1'b0;
                    if (mode && run && !r_halted) begin
                        r_mode  <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (!mode && man_go) begin
                        r_mode   <= 1'b0;
                        r_man_a  <= man_a;
                        r_man_b  <= man_b;
                        r_man_op <= man_op;
                        r_state  <= S_EXEC;
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_mode && w_op == 3'd7) begin
                        // Control op: no result update, no frame
                        if (w_halt_op) begin
                            r_halted <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_pc    <= (r_acc != '0) ? w_imm[AW-1:0] : r_pc + AW'(1);
                            r_state <= run ? S_FETCH : S_IDLE;
                        end
                    end else begin
                        r_result   <= w_res;
                        r_z        <= (w_res == '0);
                        r_v        <= w_v;
                        r_done     <= 1'b1;
                        if (r_mode) begin
                            r_acc <= w_res[DATA_W-1:0];
                            r_pc  <= r_pc + AW'(1);
                        end
                        // Start bit of byte 0 goes out together with done
                        r_tx_sr    <= w_res;
                        r_byte_cnt <= CW'(NB - 1);
                        r_bit      <= '0;
                        r_baud     <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (r_baud == BW'(CLK_DIV - 1)) begin
                        r_baud <= '0;
                        if (r_bit == 4'd9) begin
                            if (r_byte_cnt == '0) begin
                                r_busy <= 1'b0;
                                r_tx   <= 1'b1;
                                if (mode && run) begin
                                    r_mode  <= 1'b1;
                                    r_state <= S_FETCH;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                // Back-to-back: next byte's start bit, no gap
                                r_byte_cnt <= r_byte_cnt - CW'(1);
                                r_tx_sr    <= r_tx_sr >> 8;
                                r_bit      <= '0;
                                r_tx       <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 4'd1;
                            r_tx  <= w_frame[r_bit + 4'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign flag_z    = r_z;
    assign flag_v    = r_v;
    assign halted    = r_halted;
    assign done      = r_done & ena;
    assign uart_tx   = r_tx;
    assign uart_busy = r_busy;
endmodule

// File: tb/tb_jsilicon_core_v2.sv
// Bench for jsilicon_core_v2: random manual ops and CPU programs checked
// against an instruction-level reference model and a UART bit receiver.
module tb_jsilicon_core_v2;
    localparam int DW  = 8;
    localparam int CKD = 4;
    localparam int NB  = 2;

    logic        clk = 1'b0;
    logic        rst, ena, mode, man_go, run, prog_we;
    logic [7:0]  man_a, man_b;
    logic [2:0]  man_op;
    logic [2:0]  prog_addr;
    logic [6:0]  prog_wdata;
    logic [15:0] result;
    logic [7:0]  acc;
    logic [2:0]  pc;
    logic        flag_z, flag_v, halted, done, uart_tx, uart_busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: program image and architectural CPU state
    int prog_op [8];
    int prog_imm[8];
    int m_acc = 0, m_pc = 0;
    bit m_halt = 0;

    jsilicon_core_v2 #(.DATA_W(DW), .IMM_W(4), .PROG_DEPTH(8), .CLK_DIV(CKD)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .man_a(man_a), .man_b(man_b), .man_op(man_op), .man_go(man_go),
        .run(run), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .result(result), .acc(acc), .pc(pc), .flag_z(flag_z), .flag_v(flag_v),
        .halted(halted), .done(done), .uart_tx(uart_tx), .uart_busy(uart_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic meaning of each opcode
    task automatic model_alu(input int op, input int a, input int b, output int res, output bit v);
        v = 0;
        case (op)
            0: begin res = a + b; v = (res > 255); end
            1: begin res = (a - b) & 255; v = (a < b); end
            2: begin res = a * b; v = (res > 255); end
            3: if (b == 0) begin res = 255; v = 1; end else res = a / b;
            4: res = b;
            5: res = (a == b) ? 1 : 0;
            6: res = (a > b) ? 1 : 0;
            default: res = 0;
        endcase
    endtask

    // One instruction: kind 1 = ALU (res/v valid), 0 = branch, 2 = halt
    task automatic m_step(output int kind, output int res, output bit v);
        int op, imm;
        op = prog_op[m_pc]; imm = prog_imm[m_pc];
        res = 0; v = 0;
        if (op == 7) begin
            if (imm == 15) begin m_halt = 1; kind = 2; end
            else begin m_pc = (m_acc != 0) ? imm % 8 : (m_pc + 1) % 8; kind = 0; end
        end else begin
            model_alu(op, m_acc, imm, res, v);
            m_acc = res & 255;
            m_pc  = (m_pc + 1) % 8;
            kind  = 1;
        end
    endtask

    task automatic m_next(output int kind, output int res, output bit v);
        kind = 0;
        for (int i = 0; i < 64 && kind == 0; i++) m_step(kind, res, v);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        m_acc = 0; m_pc = 0; m_halt = 0;
    endtask

    task automatic load(input int addr, input int op, input int imm);
        @(negedge clk);
        prog_we = 1; prog_addr = addr[2:0]; prog_wdata = {op[2:0], imm[3:0]};
        prog_op[addr] = op; prog_imm[addr] = imm;
        @(negedge clk); prog_we = 0;
    endtask

    // Manual transaction; receives both bytes from uart_tx at mid-bit.
    // freeze_at >= 0 drops ena for 50 cycles at that TX cycle.
    task automatic do_man(input int op, input int a, input int b, input int freeze_at);
        int er, c, lim; bit ev, seen;
        logic [19:0] rx, ef; logic [15:0] e16;
        model_alu(op, a, b, er, ev);
        e16 = er[15:0];
        ef  = {1'b1, e16[15:8], 1'b0, 1'b1, e16[7:0], 1'b0};
        @(negedge clk);
        mode = 0; man_op = op[2:0]; man_a = a[7:0]; man_b = b[7:0]; man_go = 1;
        @(negedge clk); man_go = 0;
        chk("man_done_early", done, 0);
        lim = 0; seen = 0;
        while (!seen && lim < 10) begin
            @(negedge clk); lim++;
            if (done) seen = 1;
        end
        chk("man_latency", lim, 1);
        if (!seen) return;
        chk("man_result", result, er);
        chk("man_v", flag_v, ev);
        chk("man_z", flag_z, er == 0);
        chk("man_busy_start", uart_busy, 1);
        c = 0; rx = '1;
        while (uart_busy && c < 400) begin
            if (c % CKD == CKD / 2 && c / CKD < 20) rx[c / CKD] = uart_tx;
            if (c == freeze_at) begin
                ena = 0;
                repeat (50) @(negedge clk);
                chk("frz_tx", uart_tx, ef[c / CKD]);
                chk("frz_busy", uart_busy, 1);
                chk("frz_pc", pc, m_pc);
                chk("frz_done", done, 0);
                ena = 1;
            end
            @(negedge clk); c++;
        end
        chk("busy_cycles", c, NB * 10 * CKD);
        chk("rx_byte0", rx[8:1], e16[7:0]);
        chk("rx_byte1", rx[18:11], e16[15:8]);
        chk("rx_framing", {rx[19], rx[10], rx[9], rx[0]}, 4'b1010);
        chk("idle_tx", uart_tx, 1);
    endtask

    // CPU run: checks each done against the model. rst_at > 0 resets
    // mid-frame after that many completions.
    task automatic cpu_run(input int n_done, input bit expect_halt, input int rst_at);
        int got, ntx, cyc, kind, er; bit ev, prev_busy;
        got = 0; ntx = 0; cyc = 0; prev_busy = 0;
        @(negedge clk); mode = 1; run = 1;
        while (cyc < 5000) begin
            @(negedge clk); cyc++;
            if (uart_busy && !prev_busy) ntx++;
            prev_busy = uart_busy;
            if (done) begin
                m_next(kind, er, ev);
                chk("cpu_kind", kind, 1);
                chk("cpu_result", result, er);
                chk("cpu_v", flag_v, ev);
                chk("cpu_z", flag_z, er == 0);
                chk("cpu_acc", acc, m_acc);
                chk("cpu_pc", pc, m_pc);
                got++;
                if (rst_at != 0 && got == rst_at) begin
                    repeat (6) @(negedge clk);
                    chk("pre_rst_busy", uart_busy, 1);
                    run = 0;
                    pulse_rst();
                    chk("rst_tx", uart_tx, 1);
                    chk("rst_busy", uart_busy, 0);
                    chk("rst_pc", pc, 0);
                    chk("rst_acc", acc, 0);
                    return;
                end
                if (!expect_halt && got == n_done) run = 0;
            end
            if (expect_halt ? halted : (got == n_done && !uart_busy)) break;
        end
        chk("cpu_timeout", cyc < 5000, 1);
        chk("done_count", got, n_done);
        chk("tx_count", ntx, n_done);
        if (expect_halt) begin
            m_next(kind, er, ev);
            chk("halt_model", kind, 2);
            chk("halted", halted, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_acc", acc, m_acc);
        end else begin
            chk("end_pc", pc, m_pc);
            chk("end_acc", acc, m_acc);
        end
    endtask

    initial begin
        rst = 1; ena = 1; mode = 0; man_go = 0; run = 0; prog_we = 0;
        man_a = 0; man_b = 0; man_op = 0; prog_addr = 0; prog_wdata = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_result", result, 0);
        chk("rst_acc0", acc, 0);
        chk("rst_pc0", pc, 0);
        chk("rst_flags", {flag_z, flag_v, halted, done}, 0);
        chk("rst_uart", {uart_tx, uart_busy}, 2'b10);

        // Directed manual cases, including zero divisor and zero result
        do_man(0, 200, 100, -1);
        do_man(2, 15, 12, -1);
        do_man(3, 9, 0, -1);
        do_man(1, 0, 0, -1);
        do_man(7, 5, 6, -1);
        do_man(0, 255, 255, 25);

        // Random manual traffic
        for (int i = 0; i < 12; i++)
            do_man($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), -1);

        // Countdown loop ending in HALT
        load(0, 4, 3); load(1, 1, 1); load(2, 7, 1); load(3, 7, 15);
        cpu_run(4, 1, 0);
        run = 0;
        repeat (2) @(negedge clk);
        chk("halt_clear", halted, 0);

        // Reset mid-frame, then rerun to show the program survived
        pulse_rst();
        cpu_run(4, 1, 2);
        cpu_run(4, 1, 0);
        run = 0;

        // Eight LDI words, nine instructions: pc wraps back to word 0
        pulse_rst();
        for (int i = 0; i < 8; i++) load(i, 4, $urandom_range(1, 15));
        cpu_run(9, 0, 0);

        // Random straight-line program
        pulse_rst();
        for (int i = 0; i < 8; i++) load(i, $urandom_range(0, 6), $urandom_range(0, 15));
        cpu_run(12, 0, 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
